cnn_fifo_delay_ctrl: RTL and testbench
======================================

# cnn_fifo_delay_ctrl

Sequencing controller for the CNN sample-delay FIFO (`cnn_fifo_delay`). It converts a streamed input into the same stream delayed by exactly `DELAY` valid samples, and drives the FIFO's `write`/`read` strobes. Operation has three phases per frame: prefill, steady state and end-of-frame drain. It sits between a producer stage and the FIFO instance, and presents a valid-qualified delayed output to the next conv stage.

## Interface
- `DATA_WIDTH`, 32, sample width; must match the FIFO.
- `DELAY`, 13, delay in valid samples; range 1..FIFO depth (13).
- `COUNT_WIDTH`, 4, width of the occupancy counter; must hold `DELAY`.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  input sample valid.
- `data_in`  in  DATA_WIDTH  input sample.
- `frame_end`  in  1  marks the last sample of a frame; sampled only with `valid_in`.
- `in_ready`  out  1  controller accepts input; low only in DRAIN.
- `fifo_write`  out  1  FIFO write strobe.
- `fifo_read`  out  1  FIFO read strobe.
- `fifo_data_in`  out  DATA_WIDTH  FIFO write data, equal to `data_in`.
- `fifo_data_out`  in  DATA_WIDTH  FIFO read data; registered, valid 1 cycle after `fifo_read`.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_empty`  in  1  FIFO empty flag.
- `valid_out`  out  1  `data_out` holds a delayed sample.
- `data_out`  out  DATA_WIDTH  delayed sample, equal to `fifo_data_out`.
- `level`  out  COUNT_WIDTH  number of samples held in the FIFO.
- `busy`  out  1  state is not IDLE.
- `err`  out  1  sticky protocol/overflow error flag.

## Operation
- States: IDLE, FILL, STEADY, DRAIN. An accepted sample is `acc = valid_in & in_ready`.
- **IDLE:** `level` = 0.
  - `acc` → write, `level` = 1.
  - Next state: FILL. If `DELAY` == 1, next state is STEADY.
  - `acc & frame_end` → DRAIN, taking priority over both.
- **FILL:** `acc` → write only, `level`++.
  - When `level` reaches `DELAY`, go to STEADY.
  - `acc & frame_end` → DRAIN after the increment.
- **STEADY:** `acc` → write and read in the same cycle; `level` stays at `DELAY`.
  - `acc & frame_end` → DRAIN.
- **DRAIN:** `in_ready` = 0; one read per cycle while `level` > 0, with `level`-- each read.
  - The cycle the last read issues (`level` 1→0), the next state is IDLE.
- Combinational outputs:
  - `fifo_write` = `acc`, gated off if `fifo_full` and no read in the same cycle.
  - `fifo_read` = (STEADY & `acc`) | (DRAIN & `level` != 0), gated off if `fifo_empty`.
- `err` sets on any of:
  - `valid_in` while `in_ready` = 0 (the sample is dropped);
  - a write suppressed by `fifo_full`;
  - a read suppressed by `fifo_empty`;
  - `frame_end` without `valid_in`, which is otherwise ignored.
- `err` clears only on reset.
- `level` tracks only the strobes actually issued: +1 write-only, −1 read-only, 0 for both or neither.
- `level` never exceeds `DELAY` and never goes below 0.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release):
  - state = IDLE, `level` = 0, `valid_out` = 0, `err` = 0;
  - `busy` = 0, `in_ready` = 1, `fifo_write` = 0, `fifo_read` = 0.
- Reset mid-frame abandons the frame; the FIFO shares `reset` and empties with it.
- `fifo_write`/`fifo_read` are asserted in the same cycle as `valid_in`; there is no input registering.
- `valid_out` is a register equal to `fifo_read` delayed by 1 cycle.
- Delayed sample k appears 1 cycle after input sample k+`DELAY` is accepted.
- Drain: one output per cycle, with no gaps.
- `in_ready` rises in the cycle the state becomes IDLE; a new frame may start in that cycle.

## Test plan
- **Reset:** `DELAY`=3, assert `reset`=0 mid-STEADY → the same cycle, `level`=0, `valid_out`=0, `busy`=0, `err`=0, `fifo_read`=0.
- **Steady stream:** `DELAY`=3, samples A..E back-to-back in cycles 0–4, `frame_end` with E.
  - `level` = 1,2,3,3,3.
  - `valid_out` in cycles 4–8 with data A,B,C,D,E.
  - DRAIN reads in cycles 5–7; `busy` falls in cycle 8.
- **Short frame:** `DELAY`=3, A,B with `frame_end` on B (cycles 0–1) → DRAIN reads in cycles 2–3, `valid_out` in cycles 3–4 with A,B, IDLE in cycle 4.
- **Gapped input:** `DELAY`=2, `valid_in` pattern 1,0,1,0,1 → no read until the third sample; the first output is A, one cycle after the third sample; `level` holds during gaps.
- **Input during drain:** `valid_in`=1 while in DRAIN → `in_ready`=0, no `fifo_write`, `err`=1 and stays 1 until reset.
- **`DELAY`=1 back-to-back:** A,B,C → outputs A,B,C, each 1 cycle after the next sample is accepted; `level` never exceeds 1.

Source files
------------

// File: rtl/cnn_fifo_delay_ctrl.sv
// cnn_fifo_delay_ctrl
//
// Sequencing controller for the CNN sample-delay FIFO. Turns an input stream
// into the same stream delayed by DELAY accepted samples by steering the
// FIFO write/read strobes through prefill (FILL), steady state (STEADY) and
// end-of-frame drain (DRAIN).
//
// Ports:
//   clk            single clock, all state updates on its rising edge
//   reset          asynchronous active-low reset (FIFO shares it)
//   valid_in       input sample valid
//   data_in        input sample
//   frame_end      last sample of a frame, qualified by valid_in
//   in_ready       controller accepts input (low only while draining)
//   fifo_write     FIFO write strobe
//   fifo_read      FIFO read strobe
//   fifo_data_in   FIFO write data (passthrough of data_in)
//   fifo_data_out  FIFO registered read data
//   fifo_full      FIFO full flag
//   fifo_empty     FIFO empty flag
//   valid_out      data_out holds a delayed sample (fifo_read delayed 1 cycle)
//   data_out       delayed sample (passthrough of fifo_data_out)
//   level          samples currently held in the FIFO
//   busy           controller is not idle
//   err            sticky protocol/overflow error, cleared only by reset
module cnn_fifo_delay_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int DELAY       = 13,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   frame_end,
    output logic                   in_ready,
    output logic                   fifo_write,
    output logic                   fifo_read,
    output logic [DATA_WIDTH-1:0]  fifo_data_in,
    input  logic [DATA_WIDTH-1:0]  fifo_data_out,
    input  logic                   fifo_full,
    input  logic                   fifo_empty,
    output logic                   valid_out,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [COUNT_WIDTH-1:0] level,
    output logic                   busy,
    output logic                   err
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STEADY,
        DRAIN
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] DELAY_C = COUNT_WIDTH'(DELAY);

    state_t                 state_reg, state_next;
    logic [COUNT_WIDTH-1:0] level_reg, level_next;
    logic                   valid_out_reg;
    logic                   err_reg, err_next;
    logic                   acc;
    logic                   rd_req;

    always_comb begin
        in_ready   = (state_reg != DRAIN);
        // Nothing is accepted while reset is held, so no strobe can reach
        // the FIFO during reset even if valid_in is high.
        acc        = valid_in & in_ready & reset;
        rd_req     = ((state_reg == STEADY) & acc) |
                     ((state_reg == DRAIN) & (level_reg != '0));
        fifo_read  = rd_req & ~fifo_empty;
        // A full FIFO can still take a write when a read frees a slot in
        // the same cycle.
        fifo_write = acc & ~(fifo_full & ~fifo_read);

        // level follows the strobes actually issued, saturating at both ends.
        level_next = level_reg;
        case ({fifo_write, fifo_read})
            2'b10: if (level_reg != DELAY_C) level_next = level_reg + 1'b1;
            2'b01: if (level_reg != '0)      level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase

        err_next = err_reg |
                   (valid_in & ~in_ready) |
                   (acc & ~fifo_write) |
                   (rd_req & ~fifo_read) |
                   (frame_end & ~valid_in);

        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (acc) begin
                    if (frame_end)        state_next = DRAIN;
                    else if (DELAY == 1)  state_next = STEADY;
                    else                  state_next = FILL;
                end
            end
            FILL: begin
                if (acc) begin
                    if (frame_end)                  state_next = DRAIN;
                    else if (level_next == DELAY_C) state_next = STEADY;
                end
            end
            STEADY: begin
                if (acc & frame_end) state_next = DRAIN;
            end
            DRAIN: begin
                // Leave as soon as the last held sample is being read, so a
                // new frame can start in the very next cycle.
                if (level_next == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            level_reg     <= '0;
            valid_out_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            level_reg     <= level_next;
            valid_out_reg <= fifo_read;
            err_reg       <= err_next;
        end
    end

    assign fifo_data_in = data_in;
    assign data_out     = fifo_data_out;
    assign valid_out    = valid_out_reg;
    assign level        = level_reg;
    assign busy         = (state_reg != IDLE);
    assign err          = err_reg;

endmodule

// File: tb/tb_cnn_fifo_delay_ctrl.sv
// Testbench for cnn_fifo_delay_ctrl. Three controller instances (DELAY = 3,
// 2, 1) each drive a small behavioural FIFO model of depth 13 with registered
// read data. Directed per-cycle vectors with hand-computed expectations.
module tb_cnn_fifo_delay_ctrl;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [2:0] valid_in  = '0;
    logic [2:0] frame_end = '0;
    logic [2:0] in_ready, fifo_write, fifo_read, fifo_full, fifo_empty;
    logic [2:0] valid_out, busy, err;
    logic [DW-1:0] data_in [3] = '{default: '0};
    logic [DW-1:0] fifo_data_in [3];
    logic [DW-1:0] fifo_data_out [3];
    logic [DW-1:0] data_out [3];
    logic [3:0]    level [3];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_inst
            logic [DW-1:0] mem [13];
            logic [3:0]    wptr, rptr;
            logic [4:0]    cnt;
            logic [DW-1:0] rd_data;

            cnn_fifo_delay_ctrl #(
                .DATA_WIDTH (DW),
                .DELAY      (3 - gi),
                .COUNT_WIDTH(4)
            ) u_dut (
                .clk          (clk),
                .reset        (reset),
                .valid_in     (valid_in[gi]),
                .data_in      (data_in[gi]),
                .frame_end    (frame_end[gi]),
                .in_ready     (in_ready[gi]),
                .fifo_write   (fifo_write[gi]),
                .fifo_read    (fifo_read[gi]),
                .fifo_data_in (fifo_data_in[gi]),
                .fifo_data_out(fifo_data_out[gi]),
                .fifo_full    (fifo_full[gi]),
                .fifo_empty   (fifo_empty[gi]),
                .valid_out    (valid_out[gi]),
                .data_out     (data_out[gi]),
                .level        (level[gi]),
                .busy         (busy[gi]),
                .err          (err[gi])
            );

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wptr    <= '0;
                    rptr    <= '0;
                    cnt     <= '0;
                    rd_data <= '0;
                end else begin
                    if (fifo_write[gi]) begin
                        mem[wptr] <= fifo_data_in[gi];
                        wptr      <= (wptr == 4'd12) ? 4'd0 : wptr + 4'd1;
                    end
                    if (fifo_read[gi]) begin
                        rd_data <= mem[rptr];
                        rptr    <= (rptr == 4'd12) ? 4'd0 : rptr + 4'd1;
                    end
                    cnt <= cnt + 5'(fifo_write[gi]) - 5'(fifo_read[gi]);
                end
            end

            assign fifo_data_out[gi] = rd_data;
            assign fifo_full[gi]     = (cnt == 5'd13);
            assign fifo_empty[gi]    = (cnt == 5'd0);
        end
    endgenerate

    // Apply one cycle of stimulus at the falling edge; observations made after
    // this return see the combinational outputs of this cycle and the
    // registered state produced by the previous rising edge.
    task automatic drive(input int idx, input logic v, input logic [DW-1:0] d, input logic fe);
        @(negedge clk);
        valid_in[idx]  = v;
        data_in[idx]   = d;
        frame_end[idx] = fe;
        #1;
    endtask

    function automatic logic [5:0] ctl(input int i);
        return {in_ready[i], fifo_write[i], fifo_read[i], valid_out[i], busy[i], err[i]};
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (ctl(i) !== 6'b100000) begin
                mismatched++;
                $display("FAIL reset ctl inst%0d: got %b want %b", i, ctl(i), 6'b100000);
            end
            compared++;
            if (level[i] !== 4'd0) begin
                mismatched++;
                $display("FAIL reset level inst%0d: got %0d want 0", i, level[i]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ctl bits: {in_ready, fifo_write, fifo_read, valid_out, busy, err}
    task automatic test_steady_stream();
        bit            v  [10] = '{1,1,1,1,1,0,0,0,0,0};
        logic [5:0]    ec [10] = '{6'b110000, 6'b110010, 6'b110010, 6'b111010, 6'b111110,
                                   6'b001110, 6'b001110, 6'b001110, 6'b100100, 6'b100000};
        int            el [10] = '{0,1,2,3,3,3,2,1,0,0};
        int            ek [10] = '{-1,-1,-1,-1,0,1,2,3,4,-1};
        logic [DW-1:0] base = 32'hA000_0000;
        for (int c = 0; c < 10; c++) begin
            drive(0, v[c], v[c] ? base + DW'(c) : 32'hDEAD_BEEF, c == 4);
            compared++;
            if (ctl(0) !== ec[c]) begin
                mismatched++;
                $display("FAIL steady ctl c%0d: got %b want %b", c, ctl(0), ec[c]);
            end
            compared++;
            if (level[0] !== 4'(el[c])) begin
                mismatched++;
                $display("FAIL steady level c%0d: got %0d want %0d", c, level[0], el[c]);
            end
            if (ek[c] >= 0) begin
                compared++;
                if (data_out[0] !== base + DW'(ek[c])) begin
                    mismatched++;
                    $display("FAIL steady data c%0d: got %h want %h", c, data_out[0], base + DW'(ek[c]));
                end
            end
        end
    endtask

    task automatic test_short_frame();
        bit            v  [6] = '{1,1,0,0,0,0};
        logic [5:0]    ec [6] = '{6'b110000, 6'b110010, 6'b001010, 6'b001110, 6'b100100, 6'b100000};
        int            el [6] = '{0,1,2,1,0,0};
        int            ek [6] = '{-1,-1,-1,0,1,-1};
        logic [DW-1:0] base = 32'hB000_0000;
        for (int c = 0; c < 6; c++) begin
            drive(0, v[c], v[c] ? base + DW'(c) : 32'hDEAD_BEEF, c == 1);
            compared++;
            if (ctl(0) !== ec[c]) begin
                mismatched++;
                $display("FAIL short ctl c%0d: got %b want %b", c, ctl(0), ec[c]);
            end
            compared++;
            if (level[0] !== 4'(el[c])) begin
                mismatched++;
                $display("FAIL short level c%0d: got %0d want %0d", c, level[0], el[c]);
            end
            if (ek[c] >= 0) begin
                compared++;
                if (data_out[0] !== base + DW'(ek[c])) begin
                    mismatched++;
                    $display("FAIL short data c%0d: got %h want %h", c, data_out[0], base + DW'(ek[c]));
                end
            end
        end
    endtask

    task automatic test_gapped_input();
        bit            v  [10] = '{1,0,1,0,1,1,0,0,0,0};
        logic [5:0]    ec [10] = '{6'b110000, 6'b100010, 6'b110010, 6'b100010, 6'b111010,
                                   6'b111110, 6'b001110, 6'b001110, 6'b100100, 6'b100000};
        int            el [10] = '{0,1,1,2,2,2,2,1,0,0};
        int            ek [10] = '{-1,-1,-1,-1,-1,0,2,4,5,-1};
        logic [DW-1:0] base = 32'hC000_0000;
        for (int c = 0; c < 10; c++) begin
            drive(1, v[c], v[c] ? base + DW'(c) : 32'hDEAD_BEEF, c == 5);
            compared++;
            if (ctl(1) !== ec[c]) begin
                mismatched++;
                $display("FAIL gapped ctl c%0d: got %b want %b", c, ctl(1), ec[c]);
            end
            compared++;
            if (level[1] !== 4'(el[c])) begin
                mismatched++;
                $display("FAIL gapped level c%0d: got %0d want %0d", c, level[1], el[c]);
            end
            if (ek[c] >= 0) begin
                compared++;
                if (data_out[1] !== base + DW'(ek[c])) begin
                    mismatched++;
                    $display("FAIL gapped data c%0d: got %h want %h", c, data_out[1], base + DW'(ek[c]));
                end
            end
        end
    endtask

    task automatic test_frame_end_without_valid();
        bit         fe [3] = '{1,0,0};
        logic [5:0] ec [3] = '{6'b100000, 6'b100001, 6'b100001};
        for (int c = 0; c < 3; c++) begin
            drive(1, 1'b0, 32'hDEAD_BEEF, fe[c]);
            compared++;
            if (ctl(1) !== ec[c]) begin
                mismatched++;
                $display("FAIL fe_no_valid ctl c%0d: got %b want %b", c, ctl(1), ec[c]);
            end
            compared++;
            if (level[1] !== 4'd0) begin
                mismatched++;
                $display("FAIL fe_no_valid level c%0d: got %0d want 0", c, level[1]);
            end
        end
    endtask

    task automatic test_back_to_back_delay1();
        bit            v  [6] = '{1,1,1,0,0,0};
        logic [5:0]    ec [6] = '{6'b110000, 6'b111010, 6'b111110, 6'b001110, 6'b100100, 6'b100000};
        int            el [6] = '{0,1,1,1,0,0};
        int            ek [6] = '{-1,-1,0,1,2,-1};
        logic [DW-1:0] base = 32'hD000_0000;
        for (int c = 0; c < 6; c++) begin
            drive(2, v[c], v[c] ? base + DW'(c) : 32'hDEAD_BEEF, c == 2);
            compared++;
            if (ctl(2) !== ec[c]) begin
                mismatched++;
                $display("FAIL delay1 ctl c%0d: got %b want %b", c, ctl(2), ec[c]);
            end
            compared++;
            if (level[2] !== 4'(el[c])) begin
                mismatched++;
                $display("FAIL delay1 level c%0d: got %0d want %0d", c, level[2], el[c]);
            end
            if (ek[c] >= 0) begin
                compared++;
                if (data_out[2] !== base + DW'(ek[c])) begin
                    mismatched++;
                    $display("FAIL delay1 data c%0d: got %h want %h", c, data_out[2], base + DW'(ek[c]));
                end
            end
        end
    endtask

    task automatic test_input_during_drain();
        bit            v  [7] = '{1,1,1,0,0,0,0};
        logic [5:0]    ec [7] = '{6'b110000, 6'b110010, 6'b001010, 6'b001111,
                                  6'b100101, 6'b100001, 6'b100001};
        int            el [7] = '{0,1,2,1,0,0,0};
        int            ek [7] = '{-1,-1,-1,0,1,-1,-1};
        logic [DW-1:0] base = 32'hE000_0000;
        for (int c = 0; c < 7; c++) begin
            drive(0, v[c], v[c] ? base + DW'(c) : 32'hDEAD_BEEF, c == 1);
            compared++;
            if (ctl(0) !== ec[c]) begin
                mismatched++;
                $display("FAIL drain_input ctl c%0d: got %b want %b", c, ctl(0), ec[c]);
            end
            compared++;
            if (level[0] !== 4'(el[c])) begin
                mismatched++;
                $display("FAIL drain_input level c%0d: got %0d want %0d", c, level[0], el[c]);
            end
            if (ek[c] >= 0) begin
                compared++;
                if (data_out[0] !== base + DW'(ek[c])) begin
                    mismatched++;
                    $display("FAIL drain_input data c%0d: got %h want %h", c, data_out[0], base + DW'(ek[c]));
                end
            end
        end
    endtask

    task automatic test_reset_mid_steady();
        logic [DW-1:0] base = 32'hF000_0000;
        for (int c = 0; c < 4; c++) drive(0, 1'b1, base + DW'(c), 1'b0);
        drive(0, 1'b1, base + 32'd4, 1'b0);
        compared++;
        if (ctl(0) !== 6'b111111) begin
            mismatched++;
            $display("FAIL reset_mid pre ctl: got %b want %b", ctl(0), 6'b111111);
        end
        reset = 1'b0;
        #1;
        compared++;
        if (ctl(0) !== 6'b100000) begin
            mismatched++;
            $display("FAIL reset_mid ctl: got %b want %b", ctl(0), 6'b100000);
        end
        compared++;
        if (level[0] !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_mid level: got %0d want 0", level[0]);
        end
        valid_in[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        compared++;
        if (ctl(0) !== 6'b100000) begin
            mismatched++;
            $display("FAIL reset_mid post ctl: got %b want %b", ctl(0), 6'b100000);
        end
    endtask

    initial begin
        test_reset();
        test_steady_stream();
        test_short_frame();
        test_gapped_input();
        test_frame_end_without_valid();
        test_back_to_back_delay1();
        test_input_during_drain();
        test_reset_mid_steady();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
